// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC chip-select sequencer: FSM encoding,
// default parameter values and the channel-index width helper.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int DEF_CH_NUM  = 5;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DEB_CYC = 1000000;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_cs_sequencer_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, DEB_CYC stability filter
// and a one-cycle pulse when the filtered level rises.
module btn_debounce
  import adc_seq_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic press_o
);

  localparam int               CNT_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any single agreeing sample restarts the window.
  assign accept = (sync2_q != level_q) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      press_q <= accept && sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/adc_cs_sequencer.sv
// Scans enabled ADC channels: asserts one chip select, clocks DATA_W bits
// MSB first on sclk, then presents each result on a valid/ready output.
module adc_cs_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CH_NUM  = DEF_CH_NUM,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        button_REG,
  input  logic                        start,
  input  logic                        mode_cont,
  input  logic [CH_NUM-1:0]           ch_en,
  input  logic                        sdi,
  output logic [CH_NUM-1:0]           cs_n,
  output logic                        sclk,
  output logic [DATA_W-1:0]           dout,
  output logic [ch_idx_w(CH_NUM)-1:0] dout_ch,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        busy
);

  localparam int               CW      = ch_idx_w(CH_NUM);
  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               BIT_W   = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d, ch_low, ch_up;
  logic                found_low, found_up;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d, dout_q, dout_d;
  logic [CW-1:0]       dout_ch_q, dout_ch_d;
  logic                dout_valid_q, dout_valid_d;
  logic [CH_NUM-1:0]   cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                press, trigger, handshake, div_end;

  btn_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .button_i(button_REG),
    .press_o (press)
  );

  assign trigger   = start || press;
  assign handshake = dout_valid_q && dout_ready;
  assign div_end   = (div_q == DIV_MAX);

  // Descending scan: the last hit is the lowest enabled channel overall and
  // the lowest enabled channel above the current one.
  always_comb begin
    ch_low    = '0;
    ch_up     = '0;
    found_low = 1'b0;
    found_up  = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        ch_low    = CW'(i);
        found_low = 1'b1;
        if (i > int'(ch_q)) begin
          ch_up    = CW'(i);
          found_up = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      phase_q      <= 1'b0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      cs_n_q       <= '1;
      sclk_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      phase_q      <= phase_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    div_d        = div_q;
    bit_d        = bit_q;
    phase_d      = phase_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger && found_low) begin
          state_d = ST_SETUP;
          ch_d    = ch_low;
          div_d   = '0;
        end
      end
      ST_SETUP: begin
        if (div_end) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // sdi is captured on the same edge that raises sclk.
            phase_d = 1'b1;
            shreg_d = {shreg_q[DATA_W-2:0], sdi};
          end else if (bit_q == BIT_MAX) begin
            state_d = ST_HOLD;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          state_d      = ST_OUT;
          div_d        = '0;
          dout_d       = shreg_q;
          dout_ch_d    = ch_q;
          dout_valid_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (handshake) begin
          dout_valid_d = 1'b0;
          if (found_up) begin
            state_d = ST_SETUP;
            ch_d    = ch_up;
          end else if (found_low && mode_cont) begin
            state_d = ST_SETUP;
            ch_d    = ch_low;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select and serial clock are registered from next-state values so the
  // pins are glitch-free and change on the same edge as the state.
  always_comb begin
    cs_n_d = '1;
    sclk_d = 1'b1;
    if (state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD}) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cs_n_d[i] = (CW'(i) != ch_d);
      end
      sclk_d = !((state_d == ST_SHIFT) && !phase_d);
    end
  end

  assign cs_n       = cs_n_q;
  assign sclk       = sclk_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
